// File: rtl/debug_pkg.sv
// Shared definitions for the debug dump path: byte/frame geometry and the
// UART framer state encoding.
package debug_pkg;

    localparam int NB_BYTE          = 8;
    localparam int NB_CONTROL_FRAME = 32;
    localparam int BYTES_PER_FRAME  = NB_CONTROL_FRAME / NB_BYTE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    function automatic int bytes_per_frame(input int nb_frame, input int nb_byte);
        return nb_frame / nb_byte;
    endfunction

    // A frame must split into a whole, non-zero number of bytes.
    function automatic bit frame_is_byte_aligned(input int nb_frame, input int nb_byte);
        return (nb_byte > 0) && (nb_frame >= nb_byte) && ((nb_frame % nb_byte) == 0);
    endfunction

endpackage

// File: rtl/debug_sync_fifo.sv
// Synchronous word FIFO between the latch controller burst and the UART framer.
// Pushes are refused on the registered full flag; a refused push sets a sticky overflow.
module debug_sync_fifo #(
    parameter int NB_DATA    = 32,
    parameter int LOG2_DEPTH = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_push,
    input  logic               i_pop,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_empty,
    output logic               o_full,
    output logic               o_overflow
);

    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] COUNT_FULL = (LOG2_DEPTH + 1)'(DEPTH);

    logic [NB_DATA-1:0]    r_mem [DEPTH];
    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_DEPTH-1:0] r_rd_ptr;
    logic [LOG2_DEPTH:0]   r_count;
    logic                  r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_full    = (r_count == COUNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~w_full;
    assign w_pop_ok  = i_pop & ~w_empty;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (i_push && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // NOTE: storage has no reset; the count and pointers alone decide which
    // entries are valid, so stale words are never observed.
    always_ff @(posedge i_clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data     = r_mem[r_rd_ptr];
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/debug_uart_tx_framer.sv
// Buffers debug frame words and feeds them to the UART transmitter one byte at a
// time, MSB first, through a start/done handshake.
module debug_uart_tx_framer #(
    parameter int NB_CONTROL_FRAME = debug_pkg::NB_CONTROL_FRAME,
    parameter int NB_BYTE          = debug_pkg::NB_BYTE,
    parameter int LOG2_FIFO_DEPTH  = 4
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame,
    input  logic                        i_frame_valid,
    input  logic                        i_tx_done,
    output logic [NB_BYTE-1:0]          o_tx_data,
    output logic                        o_tx_start,
    output logic                        o_fifo_full,
    output logic                        o_overflow,
    output logic                        o_busy
);

    localparam int BYTES_PER_FRAME = debug_pkg::bytes_per_frame(NB_CONTROL_FRAME, NB_BYTE);
    localparam int NB_BCNT         = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(BYTES_PER_FRAME - 1);

    if (!debug_pkg::frame_is_byte_aligned(NB_CONTROL_FRAME, NB_BYTE)) begin : g_bad_frame_width
        $error("NB_CONTROL_FRAME must be a non-zero multiple of NB_BYTE");
    end

    debug_pkg::state_t r_state;
    debug_pkg::state_t w_state_next;

    logic [NB_CONTROL_FRAME-1:0] r_shift;
    logic [NB_BCNT-1:0]          r_byte_cnt;

    logic [NB_CONTROL_FRAME-1:0] w_head;
    logic                        w_empty;
    logic                        w_pop;
    logic                        w_shift;
    logic                        w_tx_start;

    debug_sync_fifo #(
        .NB_DATA    (NB_CONTROL_FRAME),
        .LOG2_DEPTH (LOG2_FIFO_DEPTH)
    ) u_fifo (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_data     (i_frame),
        .i_push     (i_frame_valid),
        .i_pop      (w_pop),
        .o_data     (w_head),
        .o_empty    (w_empty),
        .o_full     (o_fifo_full),
        .o_overflow (o_overflow)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= debug_pkg::ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_shift      = 1'b0;
        w_tx_start   = 1'b0;
        unique case (r_state)
            debug_pkg::ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = debug_pkg::ST_START;
                end
            end
            debug_pkg::ST_START: begin
                w_tx_start   = 1'b1;
                w_state_next = debug_pkg::ST_WAIT;
            end
            debug_pkg::ST_WAIT: begin
                if (i_tx_done) begin
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_state_next = debug_pkg::ST_IDLE;
                    end else begin
                        w_shift      = 1'b1;
                        w_state_next = debug_pkg::ST_START;
                    end
                end
            end
            default: w_state_next = debug_pkg::ST_IDLE;
        endcase
    end

    // The head word is loaded whole; later bytes reach the top by shifting left.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (w_pop) begin
            r_shift    <= w_head;
            r_byte_cnt <= '0;
        end else if (w_shift) begin
            r_shift    <= r_shift << NB_BYTE;
            r_byte_cnt <= r_byte_cnt + 1'b1;
        end
    end

    assign o_tx_data = r_shift[NB_CONTROL_FRAME-1 -: NB_BYTE];

    // Masked during reset so a word caught in START is not requested as it is discarded.
    assign o_tx_start = w_tx_start & ~i_reset;
    assign o_busy     = ~w_empty | (r_state != debug_pkg::ST_IDLE);

endmodule

// File: tb/tb_debug_uart_tx_framer.sv
// Directed bench for debug_uart_tx_framer: a scoreboard queue of expected bytes,
// a UART responder answering each start with a done DONE_DELAY cycles later.
module tb_debug_uart_tx_framer;

    localparam int NB_FRAME   = 32;
    localparam int NB_BYTE    = 8;
    localparam int LOG2_DEPTH = 4;
    localparam int BYTES      = NB_FRAME / NB_BYTE;
    localparam int DONE_DELAY = 10;

    logic                i_clock = 1'b0;
    logic                i_reset;
    logic [NB_FRAME-1:0] i_frame;
    logic                i_frame_valid;
    logic                i_tx_done;
    logic [NB_BYTE-1:0]  o_tx_data;
    logic                o_tx_start;
    logic                o_fifo_full;
    logic                o_overflow;
    logic                o_busy;

    always #5 i_clock = ~i_clock;

    debug_uart_tx_framer #(
        .NB_CONTROL_FRAME (NB_FRAME),
        .NB_BYTE          (NB_BYTE),
        .LOG2_FIFO_DEPTH  (LOG2_DEPTH)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_frame       (i_frame),
        .i_frame_valid (i_frame_valid),
        .i_tx_done     (i_tx_done),
        .o_tx_data     (o_tx_data),
        .o_tx_start    (o_tx_start),
        .o_fifo_full   (o_fifo_full),
        .o_overflow    (o_overflow),
        .o_busy        (o_busy)
    );

    int               n_vec = 0;
    int               n_err = 0;
    int               cyc = 0;
    logic [7:0]       exp_q[$];
    bit               auto_done = 1'b1;
    int               done_cnt = 0;
    int               last_done_cyc = -1;
    int               last_start_cyc = -1;
    int               byte_idx = 0;
    bit               word_gap_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample outputs at the falling edge, run the UART responder
    // and scoreboard, then leave inputs at their idle defaults for the caller.
    task automatic step();
        logic [7:0] exp_b;
        @(negedge i_clock);
        cyc++;
        i_frame_valid = 1'b0;
        i_tx_done     = 1'b0;
        i_reset       = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                i_tx_done     = 1'b1;
                last_done_cyc = cyc;
            end
        end
        if (o_tx_start === 1'b1) begin
            last_start_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_tx_start", {31'b0, o_tx_start}, 0);
            end else begin
                exp_b = exp_q.pop_front();
                check("tx_byte", {24'b0, o_tx_data}, {24'b0, exp_b});
            end
            if (byte_idx != 0) begin
                check("byte_gap", cyc - last_done_cyc, 1);
            end else if (word_gap_chk && last_done_cyc >= 0) begin
                check("word_gap", cyc - last_done_cyc, 2);
            end
            byte_idx = (byte_idx + 1) % BYTES;
            if (auto_done) done_cnt = DONE_DELAY;
        end
    endtask

    task automatic push(input logic [NB_FRAME-1:0] w, input bit kept);
        step();
        i_frame       = w;
        i_frame_valid = 1'b1;
        if (kept) begin
            for (int b = BYTES - 1; b >= 0; b--) exp_q.push_back(w[b*NB_BYTE +: NB_BYTE]);
        end
    endtask

    task automatic manual_done();
        step();
        i_tx_done     = 1'b1;
        last_done_cyc = cyc;
    endtask

    task automatic wait_idle(input int budget, output int idle_cyc);
        idle_cyc = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (o_busy === 1'b0 && done_cnt == 0) begin
                idle_cyc = cyc;
                break;
            end
        end
        check("idle_reached", {31'b0, (idle_cyc >= 0)}, 1);
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (15) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int push_cyc;
        int idle_cyc;

        i_reset       = 1'b1;
        i_frame       = '0;
        i_frame_valid = 1'b0;
        i_tx_done     = 1'b0;
        repeat (2) @(posedge i_clock);
        step();
        check("rst_tx_data", {24'b0, o_tx_data}, 0);
        check("rst_tx_start", {31'b0, o_tx_start}, 0);
        check("rst_fifo_full", {31'b0, o_fifo_full}, 0);
        check("rst_overflow", {31'b0, o_overflow}, 0);
        check("rst_busy", {31'b0, o_busy}, 0);

        // Single word: first start two cycles after the push.
        push(32'hAABBCCDD, 1'b1);
        push_cyc = cyc;
        step();
        check("lat_n1_no_start", {31'b0, o_tx_start}, 0);
        check("lat_n1_busy", {31'b0, o_busy}, 1);
        step();
        check("lat_n2_start", {31'b0, o_tx_start}, 1);
        check("first_start_latency", last_start_cyc - push_cyc, 2);
        wait_idle(300, idle_cyc);
        check("busy_low_after_done", idle_cyc - last_done_cyc, 1);

        // Burst of three consecutive words.
        last_done_cyc = -1;
        word_gap_chk  = 1'b1;
        push(32'h00000001, 1'b1);
        push(32'h00000002, 1'b1);
        push(32'h00000003, 1'b1);
        wait_idle(600, idle_cyc);
        check("burst_no_overflow", {31'b0, o_overflow}, 0);
        word_gap_chk = 1'b0;

        // Stray done in IDLE and in START is ignored.
        auto_done = 1'b0;
        step();
        i_tx_done = 1'b1;
        step();
        check("stray_idle_busy", {31'b0, o_busy}, 0);
        check("stray_idle_start", {31'b0, o_tx_start}, 0);
        push(32'h12345678, 1'b1);
        step();
        step();
        i_tx_done = 1'b1;
        step();
        check("stray_start_no_restart", {31'b0, o_tx_start}, 0);
        check("stray_start_data_held", {24'b0, o_tx_data}, 32'h12);
        repeat (3) step();
        manual_done();
        auto_done = 1'b1;
        wait_idle(300, idle_cyc);

        // Push and pop in the same cycle at count 15.
        auto_done = 1'b0;
        push(32'hB0B1B2B3, 1'b1);
        step();
        step();
        for (int i = 0; i < 15; i++) push(32'hC0000000 | 32'(i), 1'b1);
        step();
        check("count15_not_full", {31'b0, o_fifo_full}, 0);
        for (int b = 0; b < BYTES - 1; b++) begin
            manual_done();
            step();
        end
        word_gap_chk = 1'b1;
        manual_done();
        push(32'hC000000F, 1'b1);
        auto_done = 1'b1;
        push(32'hC0000010, 1'b1);
        check("pushpop_count_kept_15", {31'b0, o_fifo_full}, 0);
        step();
        check("pushpop_then_full", {31'b0, o_fifo_full}, 1);
        check("pushpop_no_overflow", {31'b0, o_overflow}, 0);
        wait_idle(1500, idle_cyc);
        check("pushpop_drained_not_full", {31'b0, o_fifo_full}, 0);
        word_gap_chk = 1'b0;

        // Overflow: 20 pushes while the UART is stalled on a blocker word.
        auto_done = 1'b0;
        push(32'hDEADBEEF, 1'b1);
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            push({8'h60 + 8'(i), 8'h80 + 8'(i), 8'hA0 + 8'(i), 8'hC0 + 8'(i)}, i < 16);
            check("ovf_full_track", {31'b0, o_fifo_full}, 32'(i >= 16));
            check("ovf_flag_track", {31'b0, o_overflow}, 32'(i >= 17));
        end
        step();
        check("ovf_full_final", {31'b0, o_fifo_full}, 1);
        check("ovf_flag_final", {31'b0, o_overflow}, 1);
        manual_done();
        auto_done    = 1'b1;
        word_gap_chk = 1'b1;
        wait_idle(2500, idle_cyc);
        check("ovf_sticky", {31'b0, o_overflow}, 1);
        check("ovf_drained_not_full", {31'b0, o_fifo_full}, 0);
        word_gap_chk = 1'b0;

        // Reset while waiting on the second byte of a word, with a word queued behind it.
        auto_done = 1'b0;
        push(32'h11223344, 1'b0);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        push(32'h55667788, 1'b0);
        step();
        manual_done();
        step();
        step();
        step();
        i_reset = 1'b1;
        #1;
        check("no_start_in_reset_cycle", {31'b0, o_tx_start}, 0);
        step();
        byte_idx = 0;
        check("post_rst_tx_data", {24'b0, o_tx_data}, 0);
        check("post_rst_tx_start", {31'b0, o_tx_start}, 0);
        check("post_rst_fifo_full", {31'b0, o_fifo_full}, 0);
        check("post_rst_overflow", {31'b0, o_overflow}, 0);
        check("post_rst_busy", {31'b0, o_busy}, 0);
        check("post_rst_partial_sent", exp_q.size(), 0);
        auto_done = 1'b1;
        repeat (30) step();
        push(32'hCAFEF00D, 1'b1);
        wait_idle(300, idle_cyc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/debug_uart_tx_framer.md
# debug_uart_tx_framer

Downstream stage of the debug control latches. It accepts the word stream produced while the latch controller asserts its writing strobe and buffers the words in a small FIFO. It splits each word into bytes, MSB first, and drives the UART transmitter through a start/done handshake. It decouples the one-word-per-cycle burst from the slow serial link, so that a full debug dump can be requested without back-pressure on the controller.

## Interface
- NB_CONTROL_FRAME, 32: width of an incoming frame word. Must be a multiple of NB_BYTE.
- NB_BYTE, 8: UART data width.
- LOG2_FIFO_DEPTH, 4: FIFO depth is 2**LOG2_FIFO_DEPTH words (default 16).

- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_frame  in  NB_CONTROL_FRAME  frame word from the latch controller.
- i_frame_valid  in  1  writing strobe. One word is offered per cycle while high.
- i_tx_done  in  1  one-cycle pulse from the UART TX when the current byte has been shifted out.
- o_tx_data  out  NB_BYTE  byte for the UART TX.
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
- o_fifo_full  out  1  FIFO holds 2**LOG2_FIFO_DEPTH words.
- o_overflow  out  1  sticky flag: at least one word was dropped.
- o_busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.

## Operation
- Push: when i_frame_valid=1 and o_fifo_full=0, i_frame is written at the write pointer and the count increments.
- When i_frame_valid=1 and o_fifo_full=1, the word is dropped and o_overflow is set. o_overflow stays set until reset.
- Full is evaluated on the registered count. A push is refused when full, even if a pop happens in the same cycle.
- Pointers are LOG2_FIFO_DEPTH bits wide and wrap naturally. The count is LOG2_FIFO_DEPTH+1 bits.
- Simultaneous push and pop while not full: the count is unchanged and both pointers advance.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head word into the shift register, clear the byte counter, and go to START.
  - START: o_tx_start=1 for exactly this cycle. Go to WAIT.
  - WAIT: hold. On i_tx_done, if the byte counter equals NB_CONTROL_FRAME/NB_BYTE-1, go to IDLE. Otherwise shift the register left by NB_BYTE, increment the byte counter, and go to START.
- o_tx_data is always the top NB_BYTE bits of the shift register. It is stable from START until the i_tx_done that ends the byte.
- i_tx_done outside WAIT is ignored.
- Byte order per word is MSB first: i_frame=32'hAABBCCDD is sent as AA, BB, CC, DD.

## Timing
- Reset values: o_tx_data=0, o_tx_start=0, o_fifo_full=0, o_overflow=0, o_busy=0. Pointers, count, byte counter and shift register are all 0. State is IDLE.
- Latency, with the FIFO empty and the FSM in IDLE:
  - Word pushed in cycle N.
  - FIFO non-empty in N+1; IDLE pops in N+1.
  - o_tx_start high in cycle N+2.
- Inter-byte gap: i_tx_done in cycle M gives o_tx_start in cycle M+1.
- Inter-word gap: the last i_tx_done in cycle M returns the FSM to IDLE in M+1 (pop) and gives the next o_tx_start in M+2.
- o_fifo_full and o_overflow are registered. They update the cycle after the causing push.
- Reset mid-operation: the partially sent word and all buffered words are discarded. No o_tx_start is emitted in the reset cycle or the following cycle.

## Structure
- Shared package debug_pkg:
  - NB_BYTE
  - state encoding localparams (IDLE, START, WAIT)
  - BYTES_PER_FRAME = NB_CONTROL_FRAME/NB_BYTE, with a static check of divisibility.
- Sub-module debug_sync_fifo holds the synchronous FIFO: pointers, count, full/empty, overflow flag, and registered storage. The framer instantiates it and owns the FSM and the shift register.

## Test plan
- Single word: push 32'hAABBCCDD. The bench answers each o_tx_start with i_tx_done 10 cycles later. Expect bytes AA, BB, CC, DD in order, the first o_tx_start exactly 2 cycles after the push, and o_busy low after the final done.
- Burst of 3 words in consecutive cycles (e.g. 32'h00000001, 32'h00000002, 32'h00000003): expect 12 bytes in FIFO order, o_overflow=0, and each inter-word restart 2 cycles after the last done.
- Overflow: 20 consecutive pushes with the UART stalled (no done). Expect o_fifo_full=1 after 16 words and o_overflow=1. Exactly 16 words (64 bytes) are later transmitted, and words 17-20 are absent.
- Push and pop in the same cycle at count 15: the count stays 15, with no spurious full and no word lost.
- Stray i_tx_done in IDLE and START: no state change and no extra bytes.
- Reset asserted in WAIT after 2 bytes of a word: all outputs return to their reset values. The remaining bytes and FIFO contents are never sent, and a fresh push afterwards transmits normally.
